// File: rtl/uart_tx_scheduler_if.sv
// Requester and transmitter bundle for uart_tx_scheduler.
// master: the side that raises requests and reports tx_done (requesters + UART).
// slave:  the scheduler itself.
interface uart_tx_scheduler_if;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic [3:0]  done;
    logic        tx_en;
    logic [7:0]  tx_data;
    logic        tx_done;
    logic        busy;
    logic [1:0]  grant_id;
    logic        timeout_err;

    modport master (
        output req, req_data, tx_done,
        input  ack, done, tx_en, tx_data, busy, grant_id, timeout_err
    );

    modport slave (
        input  req, req_data, tx_done,
        output ack, done, tx_en, tx_data, busy, grant_id, timeout_err
    );
endinterface

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin arbiter feeding one Hamming UART transmitter.
// Optional feature: define TX_TIMEOUT_EN to add the WAIT_DONE watchdog.
module uart_tx_scheduler #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 8192
) (
    input  logic             clk_50M,
    input  logic             rst_n,
    uart_tx_scheduler_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    // Elaboration-time guard: the watchdog needs at least two counts.
    if (TIMEOUT_CYCLES < 2) begin : g_cfg_check
        $error("uart_tx_scheduler: TIMEOUT_CYCLES must be >= 2");
    end

    state_t      state, state_nxt;
    logic [1:0]  last_grant, last_grant_nxt;
    logic [1:0]  grant_q, grant_nxt;
    logic [7:0]  data_q, data_nxt;
    logic [3:0]  ack_q, ack_nxt;
    logic [3:0]  done_q, done_nxt;
    logic        tx_en_q, tx_en_nxt;
    logic        busy_q, busy_nxt;
    logic [1:0]  winner;
    logic        found;

`ifdef TX_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_q, wd_nxt;
    logic            to_q, to_nxt;
`endif

    // Rotating priority search starting just after the last served requester.
    always_comb begin
        winner = 2'd0;
        found  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && bus.req[2'(last_grant + 2'(k) + 2'd1)]) begin
                winner = 2'(last_grant + 2'(k) + 2'd1);
                found  = 1'b1;
            end
        end
    end

    // Next-state and registered-output values.
    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        grant_nxt      = grant_q;
        data_nxt       = data_q;
        ack_nxt        = 4'b0000;
        done_nxt       = 4'b0000;
        tx_en_nxt      = 1'b0;
`ifdef TX_TIMEOUT_EN
        wd_nxt         = '0;
        to_nxt         = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (found) begin
                    grant_nxt = winner;
                    data_nxt  = bus.req_data[{winner, 3'b000} +: 8];
                    ack_nxt   = 4'b0001 << winner;
                    state_nxt = LAUNCH;
                end
            end
            LAUNCH: begin
                tx_en_nxt = 1'b1;
                state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (bus.tx_done) begin
                    done_nxt       = 4'b0001 << grant_q;
                    last_grant_nxt = grant_q;
                    state_nxt      = IDLE;
                end
`ifdef TX_TIMEOUT_EN
                else if (wd_q >= WD_W'(TIMEOUT_CYCLES - 1)) begin
                    to_nxt         = 1'b1;
                    last_grant_nxt = grant_q;
                    state_nxt      = IDLE;
                end else begin
                    wd_nxt = wd_q + WD_W'(1);
                end
`endif
            end
            default: state_nxt = IDLE;
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    // State and output registers, synchronous active-low reset.
    always_ff @(posedge clk_50M) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 2'd3;
            grant_q    <= 2'd0;
            data_q     <= 8'h00;
            ack_q      <= 4'b0000;
            done_q     <= 4'b0000;
            tx_en_q    <= 1'b0;
            busy_q     <= 1'b0;
`ifdef TX_TIMEOUT_EN
            wd_q       <= '0;
            to_q       <= 1'b0;
`endif
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            grant_q    <= grant_nxt;
            data_q     <= data_nxt;
            ack_q      <= ack_nxt;
            done_q     <= done_nxt;
            tx_en_q    <= tx_en_nxt;
            busy_q     <= busy_nxt;
`ifdef TX_TIMEOUT_EN
            wd_q       <= wd_nxt;
            to_q       <= to_nxt;
`endif
        end
    end

    assign bus.ack      = ack_q;
    assign bus.done     = done_q;
    assign bus.tx_en    = tx_en_q;
    assign bus.tx_data  = data_q;
    assign bus.busy     = busy_q;
    assign bus.grant_id = grant_q;
`ifdef TX_TIMEOUT_EN
    assign bus.timeout_err = to_q;
`else
    assign bus.timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler: stimulus queues expected ack/done
// events, a negedge monitor pops and compares them as the DUT emits them.
module tb_uart_tx_scheduler;

    logic clk_50M = 1'b0;
    logic rst_n   = 1'b0;
    int   total   = 0;
    int   bad     = 0;

    typedef struct packed {
        logic [3:0] ack;
        logic [7:0] data;
        logic [1:0] id;
    } ack_exp_t;

    ack_exp_t   exp_ack[$];
    logic [3:0] exp_done[$];

    uart_tx_scheduler_if bus();

    uart_tx_scheduler #(.NUM_REQ(4), .TIMEOUT_CYCLES(16)) dut (
        .clk_50M (clk_50M),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    always #10 clk_50M = ~clk_50M;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_50M);
        #1;
    endtask

    // Bounded wait: sel 0 = ack, 1 = tx_en, 2 = timeout_err.
    task automatic wait_for(input int sel, input string nm, output int cycles);
        bit hit = 0;
        cycles = 0;
        for (int i = 0; i < 60 && !hit; i++) begin
            tick();
            cycles++;
            if (sel == 0) hit = (bus.ack != 4'b0000);
            else if (sel == 1) hit = bus.tx_en;
            else hit = bus.timeout_err;
        end
        if (!hit) begin
            total++;
            bad++;
            $display("FAIL %s: event not seen within %0d cycles", nm, cycles);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_ack"},   32'(bus.ack),         32'h0);
        chk({tag, "_done"},  32'(bus.done),        32'h0);
        chk({tag, "_txen"},  32'(bus.tx_en),       32'h0);
        chk({tag, "_data"},  32'(bus.tx_data),     32'h0);
        chk({tag, "_busy"},  32'(bus.busy),        32'h0);
        chk({tag, "_grant"}, 32'(bus.grant_id),    32'h0);
        chk({tag, "_toerr"}, 32'(bus.timeout_err), 32'h0);
    endtask

    task automatic pulse_done(input logic [3:0] exp);
        bus.tx_done = 1'b1;
        if (exp != 4'b0000) exp_done.push_back(exp);
        tick();
        bus.tx_done = 1'b0;
    endtask

    // One full grant: expect ack for id/data, apply req_after, finish after delay.
    task automatic serve(input logic [1:0] id, input logic [7:0] data,
                         input logic [3:0] req_after, input int delay);
        int n;
        exp_ack.push_back({4'b0001 << id, data, id});
        wait_for(0, "ack_wait", n);
        bus.req = req_after;
        wait_for(1, "txen_wait", n);
        repeat (delay) tick();
        pulse_done(4'b0001 << id);
    endtask

    // Monitor: invariants every cycle, scoreboard pops on ack/done.
    always @(negedge clk_50M) begin
        ack_exp_t e;
        logic [3:0] d;
        total++;
        if (!$onehot0(bus.ack) || !$onehot0(bus.done) || (bus.tx_en && !bus.busy)) begin
            bad++;
            $display("FAIL invariant: ack=%b done=%b tx_en=%b busy=%b", bus.ack, bus.done, bus.tx_en, bus.busy);
        end
        if (bus.ack != 4'b0000) begin
            total++;
            if (exp_ack.size() == 0) begin
                bad++;
                $display("FAIL sb_ack: unexpected ack=%b at %0t", bus.ack, $time);
            end else begin
                e = exp_ack.pop_front();
                if ({bus.ack, bus.tx_data, bus.grant_id} !== e) begin
                    bad++;
                    $display("FAIL sb_ack: got ack=%b data=%h id=%0d expected ack=%b data=%h id=%0d",
                             bus.ack, bus.tx_data, bus.grant_id, e.ack, e.data, e.id);
                end
            end
        end
        if (bus.done != 4'b0000) begin
            total++;
            if (exp_done.size() == 0) begin
                bad++;
                $display("FAIL sb_done: unexpected done=%b at %0t", bus.done, $time);
            end else begin
                d = exp_done.pop_front();
                if (bus.done !== d) begin
                    bad++;
                    $display("FAIL sb_done: got %b expected %b", bus.done, d);
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int n;
        bus.req      = 4'b0000;
        bus.req_data = 32'h0;
        bus.tx_done  = 1'b0;

        // Reset state
        rst_n = 1'b0;
        repeat (3) tick();
        check_reset("rst");
        rst_n = 1'b1;
        tick();

        // Single request, latency and hold of tx_data
        bus.req_data = 32'h0000_A500;
        bus.req      = 4'b0010;
        exp_ack.push_back({4'b0010, 8'hA5, 2'd1});
        tick();
        chk("lat_ack",  32'(bus.ack),   32'h2);
        chk("lat_busy", 32'(bus.busy),  32'h1);
        chk("lat_txen0", 32'(bus.tx_en), 32'h0);
        bus.req = 4'b0000;
        tick();
        chk("lat_txen", 32'(bus.tx_en), 32'h1);
        tick();
        chk("txen_low", 32'(bus.tx_en), 32'h0);
        bus.req_data = 32'hFFFF_FFFF;
        repeat (3) tick();
        chk("data_hold", 32'(bus.tx_data), 32'hA5);
        chk("busy_wait", 32'(bus.busy),    32'h1);
        pulse_done(4'b0010);
        chk("done_lat",  32'(bus.done), 32'h2);
        chk("busy_idle", 32'(bus.busy), 32'h0);
        tick();
        chk("done_pulse", 32'(bus.done), 32'h0);

        // Stray tx_done in IDLE
        pulse_done(4'b0000);
        chk("stray_done", 32'(bus.done), 32'h0);
        chk("stray_busy", 32'(bus.busy), 32'h0);

        // Round robin after reset: 0,1,2,3,0
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        bus.req_data = 32'h4433_2211;
        bus.req      = 4'b1111;
        serve(2'd0, 8'h11, 4'b1111, 1);
        serve(2'd1, 8'h22, 4'b1111, 0);
        serve(2'd2, 8'h33, 4'b1111, 2);
        serve(2'd3, 8'h44, 4'b1111, 1);
        serve(2'd0, 8'h11, 4'b0000, 2);

        // last_grant=0, req=1001: requester 3 before 0
        bus.req_data = 32'h9900_0066;
        bus.req      = 4'b1001;
        serve(2'd3, 8'h99, 4'b1001, 0);
        serve(2'd0, 8'h66, 4'b0000, 0);

        // last_grant=0, req=0110: 1 then 2
        bus.req_data = 32'h00C3_5A00;
        bus.req      = 4'b0110;
        serve(2'd1, 8'h5A, 4'b0110, 3);
        serve(2'd2, 8'hC3, 4'b0000, 1);

        // Reset in WAIT_DONE aborts without done
        bus.req_data = 32'h0077_0000;
        bus.req      = 4'b0100;
        exp_ack.push_back({4'b0100, 8'h77, 2'd2});
        wait_for(0, "rst_ack_wait", n);
        bus.req = 4'b0000;
        wait_for(1, "rst_txen_wait", n);
        tick();
        rst_n = 1'b0;
        tick();
        check_reset("rst_mid");
        rst_n = 1'b1;
        pulse_done(4'b0000);
        chk("rst_no_done", 32'(bus.done), 32'h0);
        chk("rst_no_busy", 32'(bus.busy), 32'h0);
        bus.req_data = 32'h4433_2211;
        bus.req      = 4'b1111;
        serve(2'd0, 8'h11, 4'b0000, 1);

        // Watchdog (or indefinite wait without it), then next requester
        bus.req_data = 32'h0000_BBAA;
        bus.req      = 4'b0011;
        exp_ack.push_back({4'b0010, 8'hBB, 2'd1});
        wait_for(0, "to_ack_wait", n);
        wait_for(1, "to_txen_wait", n);
`ifdef TX_TIMEOUT_EN
        wait_for(2, "to_wait", n);
        chk("to_latency", 32'(n), 32'd16);
        chk("to_no_done", 32'(bus.done), 32'h0);
        chk("to_idle",    32'(bus.busy), 32'h0);
        tick();
        chk("to_pulse", 32'(bus.timeout_err), 32'h0);
`else
        repeat (40) tick();
        chk("nowd_busy",  32'(bus.busy),        32'h1);
        chk("nowd_toerr", 32'(bus.timeout_err), 32'h0);
        pulse_done(4'b0010);
`endif
        serve(2'd0, 8'hAA, 4'b0000, 1);

        repeat (4) tick();
        chk("sb_ack_empty",  32'(exp_ack.size()),  32'd0);
        chk("sb_done_empty", 32'(exp_done.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_scheduler.md
UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 Parameter NUM_REQ, 4, number of requesters (fixed at 4 in this revision).
REQ-002 Parameter TIMEOUT_CYCLES, 8192, WAIT_DONE watchdog limit in clk_50M cycles (used only under TX_TIMEOUT_EN).
REQ-003 clk_50M  input  1  system clock, 50 MHz, all logic on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 req  input  4  bit i high = requester i has a byte pending.
REQ-006 req_data  input  32  requester i byte on lane [8i+7:8i].
REQ-007 ack  output  4  one-cycle one-hot pulse: requester i byte captured.
REQ-008 done  output  4  one-cycle one-hot pulse: requester i byte fully transmitted.
REQ-009 tx_en  output  1  start strobe to the Hamming UART transmitter.
REQ-010 tx_data  output  8  byte to the transmitter, held stable from capture until tx_done.
REQ-011 tx_done  input  1  one-cycle completion pulse from the transmitter.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 grant_id  output  2  index of the requester currently owning the transmitter.
REQ-014 timeout_err  output  1  one-cycle pulse on watchdog expiry (constant 0 without TX_TIMEOUT_EN).

Function
REQ-015 FSM states SHALL be IDLE, LAUNCH, WAIT_DONE; all outputs registered.
REQ-016 IDLE: when req != 0, the scheduler SHALL select the first set bit searching from (last_grant+1) mod 4 upward with wrap-around.
REQ-017 On that edge: grant_id <= winner, tx_data <= winner lane, ack[winner] <= 1, state <= LAUNCH.
REQ-018 LAUNCH: tx_en SHALL be 1 for exactly this one cycle; next state WAIT_DONE.
REQ-019 WAIT_DONE: on tx_done=1, done[grant_id] <= 1, last_grant <= grant_id, state <= IDLE.
REQ-020 Latency: req rising in IDLE at cycle N -> ack at N+1, tx_en at N+2; new arbitration no earlier than the cycle after done.
REQ-021 tx_en SHALL never be high outside LAUNCH; tx_data SHALL not change outside the IDLE capture edge.
REQ-022 tx_done while not in WAIT_DONE SHALL be ignored.
REQ-023 req is sampled only in IDLE; deasserting req after ack does not cancel the transfer.
REQ-024 A requester holding req high after done re-enters arbitration at lowest priority relative to others pending.
REQ-025 ack and done SHALL be zero or one-hot at all times.

Reset
REQ-026 rst_n=0 at a rising edge SHALL force state IDLE, last_grant=3 (requester 0 first), tx_en=0, tx_data=0, ack=0, done=0, busy=0, grant_id=0, timeout_err=0, watchdog=0.
REQ-027 Reset mid-transfer SHALL abort without a done pulse; the in-flight frame on the line is not tracked further.

Configuration
REQ-028 Macro TX_TIMEOUT_EN defined: a watchdog SHALL count cycles in WAIT_DONE; on reaching TIMEOUT_CYCLES without tx_done it pulses timeout_err, sets last_grant <= grant_id, returns to IDLE, no done pulse.
REQ-029 tx_done in the same cycle as watchdog expiry SHALL take priority (done, no timeout_err).
REQ-030 Macro undefined: no watchdog logic, WAIT_DONE waits indefinitely, timeout_err tied 0; port list unchanged.

Verification
REQ-031 Single req=4'b0010, req_data lane1=8'hA5 -> ack=4'b0010 at N+1, tx_data=8'hA5, tx_en pulse at N+2, done=4'b0010 one cycle after tx_done.
REQ-032 req=4'b1111 held after reset -> grant order 0,1,2,3,0 with one done per grant.
REQ-033 req=4'b1001 with last_grant=0 -> requester 3 granted before 0.
REQ-034 rst_n low during WAIT_DONE -> next cycle all outputs at reset values, later tx_done yields no done pulse.
REQ-035 TX_TIMEOUT_EN with TIMEOUT_CYCLES=16, tx_done never returned -> timeout_err pulse 16 cycles after entering WAIT_DONE, then IDLE, next requester granted.
REQ-036 Stray tx_done in IDLE with req=0 -> no done, busy stays 0.
